// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters, registered DE/HS/VS, pixel coords, frame/line pulses.
// Ports: clk, rst_n, en; valid, HS, VS, pixel_x, pixel_y, frame_start, line_start; rgb with VTG_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int CORD_WIDTH = 11,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BP       = 248,
  parameter int V_ACTIVE   = 1024,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 38
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  valid,
  output logic                  HS,
  output logic                  VS,
  output logic [CORD_WIDTH-1:0] pixel_x,
  output logic [CORD_WIDTH-1:0] pixel_y,
  output logic                  frame_start,
  output logic                  line_start
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [23:0]           rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORD_WIDTH-1:0] HA     = CORD_WIDTH'(H_ACTIVE);
  localparam logic [CORD_WIDTH-1:0] H_LAST = CORD_WIDTH'(H_TOTAL - 1);
  localparam logic [CORD_WIDTH-1:0] HS_BEG = CORD_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CORD_WIDTH-1:0] HS_END = CORD_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORD_WIDTH-1:0] VA     = CORD_WIDTH'(V_ACTIVE);
  localparam logic [CORD_WIDTH-1:0] V_LAST = CORD_WIDTH'(V_TOTAL - 1);
  localparam logic [CORD_WIDTH-1:0] VS_BEG = CORD_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CORD_WIDTH-1:0] VS_END = CORD_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state, state_n;

  logic [CORD_WIDTH-1:0] h_cnt, v_cnt;
  logic [CORD_WIDTH-1:0] h_n, v_n;
  logic act;
  logic valid_d;
  logic hs_win, vs_win;

  // The first enabled cycle only arms the raster; the counters sit at
  // (0,0) for that cycle so pixel (0,0) leaves on the following edge.
  always_comb begin
    state_n = state;
    h_n     = h_cnt;
    v_n     = v_cnt;
    act     = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      h_n     = '0;
      v_n     = '0;
    end else begin
      unique case (state)
        S_IDLE: state_n = S_RUN;
        S_RUN: begin
          act = 1'b1;
          if (h_cnt == H_LAST) begin
            h_n = '0;
            v_n = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end else begin
            h_n = h_cnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign valid_d = act && (h_cnt < HA) && (v_cnt < VA);
  assign hs_win  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_win  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      state       <= state_n;
      h_cnt       <= h_n;
      v_cnt       <= v_n;
      valid       <= valid_d;
      HS          <= ~(act & hs_win);
      VS          <= ~(act & vs_win);
      frame_start <= act && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= act && (h_cnt == '0) && (v_cnt < VA);
      if (valid_d) begin
        pixel_x <= h_cnt;
        pixel_y <= v_cnt;
      end
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [CORD_WIDTH-1:0] BAR_W = CORD_WIDTH'(H_ACTIVE / 8);

  logic [CORD_WIDTH-1:0] bar_full;
  logic [23:0]           bar_rgb;

  assign bar_full = h_cnt / BAR_W;

  always_comb begin
    bar_rgb = 24'h000000;
    if (bar_full < CORD_WIDTH'(8)) begin
      case (bar_full[2:0])
        3'd0: bar_rgb = 24'hFFFFFF;
        3'd1: bar_rgb = 24'hFFFF00;
        3'd2: bar_rgb = 24'h00FFFF;
        3'd3: bar_rgb = 24'h00FF00;
        3'd4: bar_rgb = 24'hFF00FF;
        3'd5: bar_rgb = 24'hFF0000;
        3'd6: bar_rgb = 24'h0000FF;
        default: bar_rgb = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= 24'h000000;
    end else begin
      rgb <= valid_d ? bar_rgb : 24'h000000;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen on a scaled raster so whole frames fit.
// Scoreboard of expected outputs per edge plus line/frame timing measurements.
module tb_video_timing_gen;

  localparam int CW  = 11;
  localparam int HA  = 64;
  localparam int HF  = 4;
  localparam int HSY = 6;
  localparam int HB  = 6;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VA  = 12;
  localparam int VF  = 1;
  localparam int VSY = 3;
  localparam int VB  = 2;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FRM = HT * VT;

  typedef struct packed {
    logic          valid;
    logic          hs;
    logic          vs;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          fs;
    logic          ls;
    logic [23:0]   rgb;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          valid;
  logic          HS;
  logic          VS;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_start;
  logic          line_start;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0]   rgb;
`endif

  always #5 clk = ~clk;

  video_timing_gen #(
    .CORD_WIDTH(CW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .valid(valid),
    .HS(HS),
    .VS(VS),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .frame_start(frame_start),
    .line_start(line_start)
`ifdef VTG_TEST_PATTERN_EN
    ,
    .rgb(rgb)
`endif
  );

  int checks = 0;
  int errors = 0;

  obs_t sbq[$];
  int          m_p = -1;
  logic [CW-1:0] m_px = '0;
  logic [CW-1:0] m_py = '0;

  int cyc = 0;
  int f0, last_fs, fs_period, last_ls, ls_period;
  int n_valid, n_hs_low, n_vs_low, n_ls;
  int valid_run, valid_len, hs_run, hs_len, vs_run, vs_len;
  int valid_fall, fp_gap, vs_fall;
  obs_t prev;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.valid = valid;
    o.hs    = HS;
    o.vs    = VS;
    o.px    = pixel_x;
    o.py    = pixel_y;
    o.fs    = frame_start;
    o.ls    = line_start;
`ifdef VTG_TEST_PATTERN_EN
    o.rgb   = rgb;
`else
    o.rgb   = 24'h0;
`endif
    return o;
  endfunction

  task automatic model_push(input logic e);
    obs_t o;
    int h, v;
    o = reset_obs();
    if (!rst_n) begin
      m_p  = -1;
      m_px = '0;
      m_py = '0;
    end else if (!e) begin
      m_p = -1;
    end else if (m_p < 0) begin
      m_p = 0;
    end else begin
      h = m_p % HT;
      v = (m_p / HT) % VT;
      o.valid = (h < HA) && (v < VA);
      if (o.valid) begin
        m_px = CW'(h);
        m_py = CW'(v);
      end
      o.hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
      o.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
      o.fs  = (h == 0) && (v == 0);
      o.ls  = (h == 0) && (v < VA);
`ifdef VTG_TEST_PATTERN_EN
      o.rgb = o.valid ? bar_rgb(h) : 24'h0;
`endif
      m_p++;
    end
    o.px = m_px;
    o.py = m_py;
    sbq.push_back(o);
  endtask

  task automatic stats_clear();
    last_fs = -1; fs_period = -1; last_ls = -1; ls_period = -1;
    n_valid = 0; n_hs_low = 0; n_vs_low = 0; n_ls = 0;
    valid_run = 0; valid_len = -1; hs_run = 0; hs_len = -1;
    vs_run = 0; vs_len = -1;
    valid_fall = -1; fp_gap = -1; vs_fall = -1;
    prev = reset_obs();
  endtask

  task automatic tick(input logic e);
    obs_t o, x;
    en = e;
    model_push(e);
    @(posedge clk);
    #1;
    cyc++;
    o = sample();
    if (sbq.size() == 0) begin
      check_eq("sb_underflow", 64'd1, 64'd0);
    end else begin
      x = sbq.pop_front();
      check_eq("cycle", 64'(o), 64'(x));
    end
`ifdef VTG_TEST_PATTERN_EN
    if (o.valid && o.px == CW'(7)) check_eq("rgb_x7", 64'(o.rgb), 64'hFFFFFF);
    if (o.valid && o.px == CW'(8)) check_eq("rgb_x8", 64'(o.rgb), 64'hFFFF00);
    if (o.valid && o.px == CW'(HA - 1)) check_eq("rgb_xlast", 64'(o.rgb), 64'h0);
    if (!o.valid && prev.valid) check_eq("rgb_blank", 64'(o.rgb), 64'h0);
`endif
    if (o.valid) n_valid++;
    if (!o.hs) n_hs_low++;
    if (!o.vs) n_vs_low++;
    if (o.fs) begin
      if (last_fs >= 0 && fs_period < 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (o.ls) begin
      n_ls++;
      if (last_ls >= 0 && ls_period < 0) ls_period = cyc - last_ls;
      last_ls = cyc;
    end
    valid_run = o.valid ? valid_run + 1 : 0;
    hs_run    = !o.hs ? hs_run + 1 : 0;
    vs_run    = !o.vs ? vs_run + 1 : 0;
    if (prev.valid && !o.valid) begin
      if (valid_len < 0) valid_len = prev_run(valid_run, 1);
      valid_fall = cyc;
    end
    if (prev.hs && !o.hs && fp_gap < 0 && valid_fall >= 0)
      fp_gap = cyc - valid_fall;
    if (prev.vs && !o.vs && vs_fall < 0) vs_fall = cyc;
    prev = o;
  endtask

  int prev_valid_run_q = 0;
  int prev_hs_run_q = 0;
  int prev_vs_run_q = 0;

  function automatic int prev_run(input int cur, input int which);
    return (which == 1) ? prev_valid_run_q : cur;
  endfunction

  always @(posedge clk) begin
    #2;
    if (!HS) prev_hs_run_q <= prev_hs_run_q + 1;
    else begin
      if (prev_hs_run_q > 0 && hs_len < 0) hs_len <= prev_hs_run_q;
      prev_hs_run_q <= 0;
    end
    if (!VS) prev_vs_run_q <= prev_vs_run_q + 1;
    else begin
      if (prev_vs_run_q > 0 && vs_len < 0) vs_len <= prev_vs_run_q;
      prev_vs_run_q <= 0;
    end
    prev_valid_run_q <= valid ? prev_valid_run_q + 1 : 0;
  end

  task automatic run_to(input int target, input string tag);
    int n;
    n = 0;
    while ((m_p % FRM) != target && n < 2 * FRM) begin
      tick(1'b1);
      n++;
    end
    if ((m_p % FRM) != target) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic check_first_px(input string tag);
    check_eq(tag, {59'd0, valid, frame_start, line_start,
                   (pixel_x == '0), (pixel_y == '0)},
             64'b11111);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    stats_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 64'(sample()), 64'(reset_obs()));

    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    check_eq("edge1_idle", 64'(valid), 64'd0);
    stats_clear();
    tick(1'b1);
    f0 = cyc;
    check_first_px("edge2_first_px");

    repeat (FRM - 1) tick(1'b1);
    check_eq("valid_per_frame", 64'(n_valid), 64'(HA * VA));
    check_eq("hs_low_per_frame", 64'(n_hs_low), 64'(HSY * VT));
    check_eq("vs_low_per_frame", 64'(n_vs_low), 64'(VSY * HT));
    check_eq("ls_per_frame", 64'(n_ls), 64'(VA));
    check_eq("valid_len", 64'(valid_len), 64'(HA));
    check_eq("hs_len", 64'(hs_len), 64'(HSY));
    check_eq("vs_len", 64'(vs_len), 64'(VSY * HT));
    check_eq("hs_after_valid", 64'(fp_gap), 64'(HF));
    check_eq("vs_start", 64'(vs_fall - f0), 64'((VA + VF) * HT));
    check_eq("line_period", 64'(ls_period), 64'(HT));
    tick(1'b1);
    check_eq("fs_period", 64'(fs_period), 64'(FRM));

    run_to(5 * HT + 30, "to_drop1");
    tick(1'b0);
    check_eq("drop_valid", 64'(valid), 64'd0);
    check_eq("drop_hs_vs", 64'({HS, VS}), 64'b11);
    check_eq("drop_hold_px", 64'(pixel_x), 64'd29);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    check_first_px("reenable_first_px");

    run_to((VA + VF) * HT + HA + HF + 1, "to_drop2");
    check_eq("pre_drop_sync", 64'({HS, VS}), 64'b00);
    tick(1'b0);
    check_eq("drop_sync_release", 64'({HS, VS}), 64'b11);
    tick(1'b1);
    tick(1'b1);
    check_first_px("reenable2_first_px");

    run_to(6 * HT + 10, "to_midreset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs", 64'(sample()), 64'(reset_obs()));
    tick(1'b1);
    tick(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    check_eq("post_reset_idle", 64'(valid), 64'd0);
    tick(1'b1);
    check_first_px("post_reset_first_px");
    repeat (2 * HT) tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
